// File: rtl/change_pkg.sv
// Shared types, constants and the range-check helper for the change responder.
package change_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        CHECK,
        RD_HI,
        RD_LO,
        WR_HI,
        WR_LO,
        DONE
    } state_t;

    localparam int ELEM_W = 48;
    localparam int DW     = 24;

    // Full 16-bit compare, so out-of-range values can never alias a legal index.
    function automatic logic in_range(
        input logic [15:0] x,
        input logic [15:0] y,
        input int unsigned rows,
        input int unsigned cols
    );
        return ({16'd0, x} < rows) && ({16'd0, y} < cols);
    endfunction

endpackage

// File: rtl/change_addr_gen.sv
// Element index, range check and registered hi/lo word addresses for one request.
// The multiply sits between the request inputs and these registers, outside the FSM.
module change_addr_gen
    import change_pkg::*;
#(
    parameter int ROWS = 20,
    parameter int COLS = 25,
    parameter int AW   = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [15:0]   x,
    input  logic [15:0]   y,
    output logic          ok,
    output logic [AW-1:0] addr_hi,
    output logic [AW-1:0] addr_lo
);

    logic [AW-1:0] idx;
    logic [AW-1:0] base;
    logic          ok_d;
    logic          ok_q;
    logic [AW-1:0] hi_d;
    logic [AW-1:0] hi_q;
    logic [AW-1:0] lo_d;
    logic [AW-1:0] lo_q;

    always_comb begin
        idx  = AW'(x) * AW'(COLS) + AW'(y);
        base = idx << 1;
        ok_d = ok_q;
        hi_d = hi_q;
        lo_d = lo_q;
        if (load) begin
            ok_d = in_range(x, y, ROWS, COLS);
            hi_d = base;
            lo_d = base | AW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ok_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            ok_q <= ok_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign ok      = ok_q;
    assign addr_hi = hi_q;
    assign addr_lo = lo_q;

endmodule

// File: rtl/change_responder.sv
// Responder for the EnableChange/EOC_Flag handshake: captures one element update,
// range-checks it and writes it as two words. CHANGE_ACCUM_EN adds read-modify-write.
module change_responder
    import change_pkg::*;
#(
    parameter int ROWS = 20,
    parameter int COLS = 25,
    parameter int AW   = 10,
    parameter int DW   = 24
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            EnableChange,
    input  logic [15:0]     X,
    input  logic [15:0]     Y,
    input  logic [2*DW-1:0] NewElement,
    output logic            EOC_Flag,
    output logic            ErrFlag,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_re,
    input  logic [DW-1:0]   mem_rdata
);

    state_t          state_d;
    state_t          state_q;
    logic            eoc_d;
    logic            eoc_q;
    logic            err_d;
    logic            err_q;
    logic            we_d;
    logic            we_q;
    logic            re_d;
    logic            re_q;
    logic            armed_d;
    logic            armed_q;
    logic [AW-1:0]   addr_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_d;
    logic [DW-1:0]   wdata_q;
    logic [2*DW-1:0] elem_d;
    logic [2*DW-1:0] elem_q;

    logic            load;
    logic            addr_ok;
    logic [AW-1:0]   addr_hi;
    logic [AW-1:0]   addr_lo;

    change_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS),
        .AW   (AW)
    ) u_addr_gen (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .x       (X),
        .y       (Y),
        .ok      (addr_ok),
        .addr_hi (addr_hi),
        .addr_lo (addr_lo)
    );

    always_comb begin
        state_d = state_q;
        eoc_d   = eoc_q;
        err_d   = err_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        elem_d  = elem_q;
        load    = 1'b0;
        // Re-arm only once the initiator has dropped its request for an edge.
        armed_d = armed_q | ~EnableChange;

        case (state_q)
            INIT: begin
                state_d = IDLE;
            end

            IDLE: begin
                eoc_d = 1'b1;
                if (EnableChange && armed_q) begin
                    load    = 1'b1;
                    elem_d  = NewElement;
                    armed_d = 1'b0;
                    eoc_d   = 1'b0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (!addr_ok) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef CHANGE_ACCUM_EN
                    re_d    = 1'b1;
                    addr_d  = addr_hi;
                    state_d = RD_HI;
`else
                    we_d    = 1'b1;
                    addr_d  = addr_hi;
                    wdata_d = elem_q[2*DW-1:DW];
                    state_d = WR_HI;
`endif
                end
            end

`ifdef CHANGE_ACCUM_EN
            RD_HI: begin
                re_d    = 1'b1;
                addr_d  = addr_lo;
                state_d = RD_LO;
            end

            // Hi read data is valid this cycle; fold it straight into the hi write.
            RD_LO: begin
                we_d    = 1'b1;
                addr_d  = addr_hi;
                wdata_d = mem_rdata + elem_q[2*DW-1:DW];
                state_d = WR_HI;
            end
`endif

            WR_HI: begin
                we_d    = 1'b1;
                addr_d  = addr_lo;
`ifdef CHANGE_ACCUM_EN
                wdata_d = mem_rdata + elem_q[DW-1:0];
`else
                wdata_d = elem_q[DW-1:0];
`endif
                state_d = WR_LO;
            end

            WR_LO: begin
                state_d = DONE;
            end

            DONE: begin
                eoc_d   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            eoc_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            armed_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            eoc_q   <= eoc_d;
            err_q   <= err_d;
            we_q    <= we_d;
            re_q    <= re_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            elem_q  <= elem_d;
        end
    end

`ifndef CHANGE_ACCUM_EN
    logic [DW-1:0] unused_rdata;
    assign unused_rdata = mem_rdata;
`endif

    assign EOC_Flag  = eoc_q;
    assign ErrFlag   = err_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_change_responder.sv
// Scoreboard bench for change_responder: stimulus queues expected writes, a monitor checks them.
module tb_change_responder;

    typedef struct {
        logic [9:0]  addr;
        logic [23:0] data;
    } wr_t;

`ifdef CHANGE_ACCUM_EN
    localparam int LAT_OK = 6;
`else
    localparam int LAT_OK = 4;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        EnableChange = 1'b0;
    logic [15:0] X = '0;
    logic [15:0] Y = '0;
    logic [47:0] NewElement = '0;
    logic        EOC_Flag;
    logic        ErrFlag;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_re;
    logic [23:0] mem_rdata;

    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [23:0] pre_data = '0;
    logic [23:0] mem [0:1023];

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    change_responder dut (
        .clock        (clock),
        .reset        (reset),
        .EnableChange (EnableChange),
        .X            (X),
        .Y            (Y),
        .NewElement   (NewElement),
        .EOC_Flag     (EOC_Flag),
        .ErrFlag      (ErrFlag),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    always #5 clock = ~clock;

    // Register-bank model: synchronous write, registered read.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (pre_we) mem[pre_addr] <= pre_data;
            else if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Monitor: every observed write must match the head of the expectation queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clock);
            if (mem_we === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write got addr=%0d data=%h want none", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        bad++;
                        $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                                 mem_addr, mem_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic do_req(input logic [15:0] x, input logic [15:0] y, input logic [47:0] e,
                          input logic [9:0] waddr, input logic [23:0] hi_exp, input logic [23:0] lo_exp,
                          input bit ok, input bit hold);
        int lat;
        @(negedge clock);
        EnableChange = 1'b1;
        X = x;
        Y = y;
        NewElement = e;
        if (ok) begin
            exp_q.push_back('{waddr, hi_exp});
            exp_q.push_back('{waddr + 10'd1, lo_exp});
        end
        @(posedge clock);
        #1;
        check("eoc_drop_on_capture", {47'd0, EOC_Flag}, 48'd0);
        // Scramble the inputs: the responder must work from its latched copy.
        X = ~x;
        Y = ~y;
        NewElement = ~e;
        lat = 0;
        while (EOC_Flag !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check(ok ? "latency_ok" : "latency_reject", 48'(lat), ok ? 48'(LAT_OK) : 48'd2);
        $display("txn x=%0d y=%0d elem=%h in_range=%0b latency=%0d err=%0b",
                 x, y, e, ok, lat, ErrFlag);
        if (!hold) begin
            @(negedge clock);
            EnableChange = 1'b0;
        end
    endtask

    initial begin
        int waited;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_eoc", {47'd0, EOC_Flag}, 48'd0);
        check("rst_err", {47'd0, ErrFlag}, 48'd0);
        check("rst_we", {47'd0, mem_we}, 48'd0);
        check("rst_addr", {38'd0, mem_addr}, 48'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 48'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("init_eoc_edge1", {47'd0, EOC_Flag}, 48'd0);
        @(posedge clock);
        #1;
        check("idle_eoc_edge2", {47'd0, EOC_Flag}, 48'd1);

        // In-range requests: 2*3 -> idx 53, 19*25+24 -> idx 499, origin
        do_req(16'd2, 16'd3, 48'hABCDEF123456, 10'd106, 24'hABCDEF, 24'h123456, 1'b1, 1'b0);
        do_req(16'd19, 16'd24, 48'h0A0B0C0D0E0F, 10'd998, 24'h0A0B0C, 24'h0D0E0F, 1'b1, 1'b0);
        do_req(16'd0, 16'd0, 48'hFFFFFF000001, 10'd0, 24'hFFFFFF, 24'h000001, 1'b1, 1'b0);
        check("err_clear_after_good", {47'd0, ErrFlag}, 48'd0);

        // Out-of-range requests
        do_req(16'd20, 16'd0, 48'h111111111111, 10'd0, 24'd0, 24'd0, 1'b0, 1'b0);
        check("err_set_x_eq_rows", {47'd0, ErrFlag}, 48'd1);
        do_req(16'd0, 16'd25, 48'h222222222222, 10'd0, 24'd0, 24'd0, 1'b0, 1'b0);
        do_req(16'hFFFF, 16'd0, 48'h333333333333, 10'd0, 24'd0, 24'd0, 1'b0, 1'b0);

        // Held request: exactly one capture until EnableChange drops (1*25+1 -> idx 26)
        do_req(16'd1, 16'd1, 48'h445566778899, 10'd52, 24'h445566, 24'h778899, 1'b1, 1'b1);
        repeat (6) @(posedge clock);
        #1;
        check("held_no_recapture", {47'd0, EOC_Flag}, 48'd1);
        @(negedge clock);
        EnableChange = 1'b0;
        do_req(16'd1, 16'd2, 48'h010203040506, 10'd54, 24'h010203, 24'h040506, 1'b1, 1'b0);
        check("err_sticky", {47'd0, ErrFlag}, 48'd1);

`ifdef CHANGE_ACCUM_EN
        // Read-modify-write: 1+2 on hi, FFFFFF+1 wraps to 0 on lo, no carry between words
        @(negedge clock);
        pre_we = 1'b1;
        pre_addr = 10'd150;
        pre_data = 24'h000001;
        @(negedge clock);
        pre_addr = 10'd151;
        pre_data = 24'hFFFFFF;
        @(negedge clock);
        pre_we = 1'b0;
        do_req(16'd3, 16'd0, 48'h000002000001, 10'd150, 24'h000003, 24'h000000, 1'b1, 1'b0);
`endif

        // Reset during the hi write: lo word (4*25+5 -> idx 105, addr 211) never written
        @(negedge clock);
        EnableChange = 1'b1;
        X = 16'd4;
        Y = 16'd5;
        NewElement = 48'h111111222222;
        exp_q.push_back('{10'd210, 24'h111111});
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (mem_we !== 1'b1 && waited < 20);
        check("wr_hi_reached", {47'd0, mem_we}, 48'd1);
        #1;
        reset = 1'b1;
        EnableChange = 1'b0;
        #1;
        check("abort_we_drop", {47'd0, mem_we}, 48'd0);
        check("abort_eoc", {47'd0, EOC_Flag}, 48'd0);
        check("abort_err_clear", {47'd0, ErrFlag}, 48'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("restart_init_eoc", {47'd0, EOC_Flag}, 48'd0);
        @(posedge clock);
        #1;
        check("restart_idle_eoc", {47'd0, EOC_Flag}, 48'd1);
        repeat (8) @(negedge clock);

        check("queue_drained", 48'(exp_q.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/change_responder.md
Name: change_responder

Overview:
- Responder end of the change-request handshake (EnableChange / X / Y / NewElement / EOC_Flag) that the stimulus side drives into the design.
- Captures one matrix-element update per request, bounds-checks (X,Y), and writes the 48-bit element into the vector-register memory as two 24-bit words.
- Raises EOC_Flag when the update is committed, which lets the initiator dump the banks or issue the next change.
- Sits inside top, between the request inputs and the flat write port of the register banks.

Parameters:
- ROWS, 20, number of valid X values (0..ROWS-1)
- COLS, 25, number of valid Y values (0..COLS-1)
- AW, 10, memory word-address width; must satisfy 2*ROWS*COLS <= 2**AW
- DW, 24, memory word width; element width is 2*DW

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- EnableChange  in  1  request valid, level; held until EOC_Flag falls
- X  in  16  element row
- Y  in  16  element column
- NewElement  in  48  element value; [47:24] hi word, [23:0] lo word
- EOC_Flag  out  1  1 = idle/committed, ready for the next request
- ErrFlag  out  1  sticky: an out-of-range request was dropped
- mem_we  out  1  word write strobe
- mem_addr  out  AW  word address
- mem_wdata  out  DW  write data
- mem_re  out  1  read strobe (only with the optional feature)
- mem_rdata  in  DW  read data, valid 1 cycle after mem_re

Behaviour:
- Reset values: EOC_Flag=0, ErrFlag=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, state=INIT, armed=1, captured registers=0.
- INIT -> IDLE unconditionally one cycle after reset deasserts. EOC_Flag=1 in IDLE.
- Capture: in IDLE, at a rising edge with EnableChange=1 and armed=1:
  - latch X, Y, NewElement;
  - clear armed and EOC_Flag;
  - go to CHECK.
- armed is set again at any edge where EnableChange=0. A request held high across completion is therefore never captured twice.
- CHECK (1 cycle):
  - idx = X*COLS + Y, computed at AW bits from 16-bit operands.
  - If X>=ROWS or Y>=COLS: set ErrFlag, perform no write, go to DONE.
  - Otherwise go to WR_HI.
- WR_HI: mem_we=1, mem_addr=2*idx, mem_wdata=NewElement[47:24].
- WR_LO: mem_we=1, mem_addr=2*idx+1, mem_wdata=NewElement[23:0].
- DONE: EOC_Flag<=1, go to IDLE.
- Latency: capture edge to EOC_Flag high is 4 cycles for an in-range request, 2 cycles when rejected.
- mem_we is high only in WR_HI and WR_LO, exactly one cycle each.
- EnableChange changing mid-operation is ignored; the latched values are used.
- Reset mid-operation aborts immediately. No further writes occur; any already-written hi word remains.
- ErrFlag clears only on reset.
- Boundaries:
  - X=ROWS-1, Y=COLS-1 is accepted (word addresses 998/999 at defaults).
  - X=ROWS or Y=COLS is rejected.
  - X=0xFFFF is rejected with no wraparound into a valid index.

Optional Feature:
- Macro: CHANGE_ACCUM_EN.
- Defined:
  - CHECK goes to RD_HI instead of WR_HI.
  - RD_HI issues mem_re for the hi word; RD_LO issues mem_re for the lo word while capturing the hi read data.
  - WR_HI writes the stored hi word + NewElement[47:24]; WR_LO writes the lo word + NewElement[23:0].
  - Each sum is an independent DW-bit add, truncated, with no carry between words.
  - In-range latency becomes 6 cycles.
- Undefined: plain overwrite; mem_re is tied to 0.

Decomposition:
- Shared package change_pkg holds:
  - state enum (INIT, IDLE, CHECK, RD_HI, RD_LO, WR_HI, WR_LO, DONE);
  - localparams ELEM_W=48, DW=24;
  - function in_range(x,y).
- One natural sub-module: change_addr_gen. It is a combinational idx and range check plus a registered hi/lo address, keeping the multiply out of the FSM.

Test Plan:
- Reset, then release -> EOC_Flag=0 during reset, 1 on the second edge after release; no mem_we during this interval.
- Request X=2, Y=3, NewElement=0xABCDEF123456 -> one write of 0xABCDEF at addr 106, then 0x123456 at addr 107; EOC_Flag high 4 cycles after capture.
- X=20, Y=0 (and X=0xFFFF, Y=0) -> no mem_we; ErrFlag=1; EOC_Flag returns after 2 cycles.
- EnableChange held high through completion -> only one capture; a second capture occurs only after EnableChange has been low for at least one edge.
- Reset asserted during WR_HI -> mem_we drops at once; addr 2*idx+1 is never written; FSM restarts in INIT.
- With CHANGE_ACCUM_EN, mem preloaded 0x000001/0xFFFFFF, NewElement=0x000002000001 -> writes 0x000003 and 0x000000; latency 6 cycles.
